axadd_error_monitor: RTL and testbench
======================================

// Module: axadd_error_monitor
// PURPOSE
//  Downstream consumer of the 16-bit approximate Sklansky prefix adder. Each accepted sample carries
//  the operands plus the adder's approximate {carry-out, sum}. The block computes the exact sum, the
//  error distance ED = |exact - approx| and accumulates error statistics over a programmed sample
//  count. Used in the PPA/accuracy evaluation harness that sits next to each approximate adder variant.
// PARAMETERS
//  WIDTH      16  operand width; must match the adder under evaluation
//  CNT_W      16  width of sample counter, num_samples, err_count
//  ACC_W      40  width of sum_ed accumulator (saturating)
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        asynchronous, active-low reset
//  start        in   1        1-cycle pulse: clear stats, latch num_samples, begin run
//  num_samples  in   CNT_W    samples per run, sampled on start
//  in_valid     in   1        sample valid
//  in_ready     out  1        block can accept a sample
//  op_a, op_b   in   WIDTH    adder operands
//  approx_sum   in   WIDTH    adder Sum output (bit 0 = LSB)
//  approx_cout  in   1        adder carry-out (MSB carry)
//  busy         out  1        high in RUN or DRAIN
//  done         out  1        1-cycle pulse on entry to DONE
//  err_count    out  CNT_W    samples with ED != 0
//  sum_ed       out  ACC_W    sum of ED over run
//  max_ed       out  WIDTH+1  largest ED seen
//  sum_sq_ed    out  2*WIDTH+2+CNT_W  sum of ED^2 (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: FSM=IDLE; in_ready, busy, done = 0; all stats and counters = 0.
//  - FSM IDLE -> RUN on start; RUN -> DRAIN when accepted == num_samples; DRAIN -> DONE when pipe
//    empty; DONE -> RUN on start (stats cleared that cycle). start with num_samples==0 -> DONE next
//    cycle, stats 0, done pulses. start while busy is ignored.
//  - Handshake: transfer when in_valid && in_ready. in_ready = (state==RUN) && (accepted < num_samples);
//    combinational from state/counter only, never from in_valid. Inputs held by sender until accepted.
//  - Pipe: S1 registers operands, exact = op_a + op_b (WIDTH+1 bits), approx = {approx_cout,approx_sum};
//    S2 registers ED = |exact - approx| (WIDTH+1 bits, unsigned magnitude); S3 updates stats.
//    Stats reflect a sample 3 cycles after its transfer. Full throughput: 1 sample/cycle, no bubbles.
//  - Stats: err_count += (ED!=0); sum_ed += ED, saturates at 2^ACC_W-1 (no wrap); max_ed = max(max_ed,ED).
//  - Outputs hold final values in DONE and IDLE until next start.
//  - Reset mid-run: immediate return to IDLE, pipe flushed, partial stats discarded (zero).
// CONFIGURATION
//  SQ_ERR_EN defined: extra S3 accumulator sum_sq_ed += ED*ED (full width, wraps never for
//    2^CNT_W samples). Multiplier in S2 (ED^2 registered alongside ED); latency unchanged.
//  SQ_ERR_EN undefined: no multiplier/accumulator synthesised; sum_sq_ed tied to 0.
// TESTING
//  - Reset: assert rst_n=0 mid-run -> next cycle busy=0, in_ready=0, all stats 0, FSM IDLE.
//  - Exact sample: num_samples=1, a=0x1234, b=0x0001, approx=0x1235, cout=0 -> done; err_count=0,
//    sum_ed=0, max_ed=0.
//  - Errored run: num_samples=2; (a=3,b=1,approx=0,cout=0) ED=4; (a=0xFFFF,b=1,approx=0,cout=0)
//    ED=0x10000 -> err_count=2, sum_ed=0x10004, max_ed=0x10000; SQ_ERR_EN: sum_sq_ed=0x1_0000_0010.
//  - Back-pressure/throughput: in_valid held high, num_samples=100 -> exactly 100 transfers, in_ready
//    drops after 100th, done 3-4 cycles later; random in_valid gaps give identical stats.
//  - num_samples=0 -> done pulse 1 cycle after start, no in_ready, stats 0; start during RUN ignored.
//  - Saturation: ACC_W=17 build, 3 samples of ED=0x10000 -> sum_ed=0x1FFFF, not wrapped.

Source files
------------

// File: rtl/axadd_error_monitor.sv
// Purpose: accuracy monitor for a WIDTH-bit approximate adder; accumulates error-distance stats per run.
// Latency: 3-stage pipe (operands -> ED -> stats); a sample's effect on stats is visible 3 cycles after transfer.
// Backpressure: in_ready depends only on state/counter, never on in_valid; 1 sample/cycle with no bubbles.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, num_samples         start pulse (clears stats, latches sample count); ignored while busy
//   in_valid/in_ready          sample handshake; op_a, op_b, approx_sum, approx_cout form the sample
//   busy, done                 busy in RUN/DRAIN; done pulses for one cycle on entry to DONE
//   err_count, sum_ed, max_ed  error statistics (sum_ed saturates at all-ones)
//   sum_sq_ed                  sum of ED^2 when built with SQ_ERR_EN defined, otherwise tied to 0
//
// Optional feature macro: SQ_ERR_EN (squared-error accumulator with the multiplier in stage 2).

module axadd_error_monitor #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16,
    parameter int ACC_W = 40
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [CNT_W-1:0]           num_samples,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           op_a,
    input  logic [WIDTH-1:0]           op_b,
    input  logic [WIDTH-1:0]           approx_sum,
    input  logic                       approx_cout,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           err_count,
    output logic [ACC_W-1:0]           sum_ed,
    output logic [WIDTH:0]             max_ed,
    output logic [2*WIDTH+2+CNT_W-1:0] sum_sq_ed
);

    localparam int EW  = WIDTH + 1;            // exact/approx/ED width
    localparam int AW1 = ACC_W + 1;            // accumulator plus overflow bit
    localparam int SQW = 2*WIDTH + 2 + CNT_W;  // squared-error accumulator width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   enter_done;

    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] accepted;

    logic             xfer;
    logic             start_ok;

    // Stage 1
    logic             s1_vld;
    logic [EW-1:0]    exact_q;
    logic [EW-1:0]    approx_q;

    // Stage 2
    logic             s2_vld;
    logic [EW-1:0]    ed_s1;
    logic [EW-1:0]    ed_q;

    // Stage 3 / stats
    logic [CNT_W-1:0] err_q;
    logic [ACC_W-1:0] sum_q;
    logic [EW-1:0]    max_q;
    logic [AW1-1:0]   sum_ext;
    logic [ACC_W-1:0] sum_nxt;

    logic done_q;

    //------------------------------------------------------------------
    // Handshake and control
    //------------------------------------------------------------------
    assign in_ready = (state == RUN) && (accepted < target);
    assign xfer     = in_valid && in_ready;
    // A new run may only begin when no samples are in flight.
    assign start_ok = start && ((state == IDLE) || (state == DONE));

    always_comb begin
        state_nxt  = state;
        enter_done = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start_ok) begin
                    if (num_samples == '0) begin
                        state_nxt  = DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (accepted == target) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Stats are final once neither pipe stage holds a sample.
                if (!s1_vld && !s2_vld) begin
                    state_nxt  = DONE;
                    enter_done = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= enter_done;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target   <= '0;
            accepted <= '0;
        end else if (start_ok) begin
            target   <= num_samples;
            accepted <= '0;
        end else if (xfer) begin
            accepted <= accepted + 1'b1;
        end
    end

    //------------------------------------------------------------------
    // Stage 1: exact sum and approximate result
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld   <= 1'b0;
            exact_q  <= '0;
            approx_q <= '0;
        end else begin
            s1_vld <= xfer;
            if (xfer) begin
                exact_q  <= {1'b0, op_a} + {1'b0, op_b};
                approx_q <= {approx_cout, approx_sum};
            end
        end
    end

    //------------------------------------------------------------------
    // Stage 2: unsigned error distance
    //------------------------------------------------------------------
    assign ed_s1 = (exact_q >= approx_q) ? (exact_q - approx_q) : (approx_q - exact_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld <= 1'b0;
            ed_q   <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                ed_q <= ed_s1;
            end
        end
    end

    //------------------------------------------------------------------
    // Stage 3: statistics
    //------------------------------------------------------------------
    // One extra bit catches overflow so the accumulator sticks at all-ones.
    assign sum_ext = {1'b0, sum_q} + AW1'(ed_q);
    assign sum_nxt = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
            sum_q <= '0;
            max_q <= '0;
        end else if (start_ok) begin
            err_q <= '0;
            sum_q <= '0;
            max_q <= '0;
        end else if (s2_vld) begin
            err_q <= err_q + {{(CNT_W-1){1'b0}}, (ed_q != '0)};
            sum_q <= sum_nxt;
            if (ed_q > max_q) begin
                max_q <= ed_q;
            end
        end
    end

`ifdef SQ_ERR_EN
    // Square computed in stage 2 alongside ED so stats latency is unchanged.
    logic [2*EW-1:0] ed_sq_q;
    logic [SQW-1:0]  sq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ed_sq_q <= '0;
        end else if (s1_vld) begin
            ed_sq_q <= ed_s1 * ed_s1;
        end
    end

    // Width covers 2^CNT_W samples of the largest square, so no wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_q <= '0;
        end else if (start_ok) begin
            sq_q <= '0;
        end else if (s2_vld) begin
            sq_q <= sq_q + SQW'(ed_sq_q);
        end
    end

    assign sum_sq_ed = sq_q;
`else
    assign sum_sq_ed = '0;
`endif

    //------------------------------------------------------------------
    // Outputs
    //------------------------------------------------------------------
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = done_q;
    assign err_count = err_q;
    assign sum_ed    = sum_q;
    assign max_ed    = max_q;

endmodule

// File: tb/tb_axadd_error_monitor.sv
module tb_axadd_error_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_samples = '0;
    logic        in_valid = 1'b0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic [15:0] approx_sum = '0;
    logic        approx_cout = 1'b0;

    logic        in_ready, busy, done;
    logic [15:0] err_count;
    logic [39:0] sum_ed;
    logic [16:0] max_ed;
    logic [49:0] sum_sq_ed;

    logic        sat_in_ready, sat_busy, sat_done;
    logic [15:0] sat_err_count;
    logic [16:0] sat_sum_ed;
    logic [16:0] sat_max_ed;
    logic [49:0] sat_sum_sq_ed;

    axadd_error_monitor dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .op_a(op_a), .op_b(op_b),
        .approx_sum(approx_sum), .approx_cout(approx_cout), .busy(busy), .done(done),
        .err_count(err_count), .sum_ed(sum_ed), .max_ed(max_ed), .sum_sq_ed(sum_sq_ed)
    );

    // Narrow-accumulator instance sharing the same stimulus, for saturation.
    axadd_error_monitor #(.WIDTH(16), .CNT_W(16), .ACC_W(17)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(sat_in_ready), .op_a(op_a), .op_b(op_b),
        .approx_sum(approx_sum), .approx_cout(approx_cout), .busy(sat_busy), .done(sat_done),
        .err_count(sat_err_count), .sum_ed(sat_sum_ed), .max_ed(sat_max_ed), .sum_sq_ed(sat_sum_sq_ed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] err;
        logic [39:0] sum;
        logic [16:0] max;
        logic [49:0] sq;
        logic [16:0] sat_sum;
        int          n_xfer;
        int          span;       // first-to-last transfer distance, -1 = unchecked
        int          start_lat;  // start-to-done distance, -1 = unchecked
    } exp_t;

    exp_t sb[$];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [49:0] sq_exp(input logic [49:0] v);
`ifdef SQ_ERR_EN
        return v;
`else
        return 50'd0;
`endif
    endfunction

    //------------------------------------------------------------------
    // Monitor: transfer accounting and result checking on done
    //------------------------------------------------------------------
    int  run_xfer = 0;
    int  first_xfer = 0;
    int  last_xfer = 0;
    int  start_cyc = 0;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (start && !busy) begin
                run_xfer  = 0;
                start_cyc = cyc;
            end
            if (in_valid && in_ready) begin
                if (run_xfer == 0) first_xfer = cyc;
                last_xfer = cyc;
                run_xfer++;
            end
            if (done) begin
                chk("done_single_cycle", {63'd0, prev_done}, 64'd0);
                chk("sat_done_aligned", {63'd0, sat_done}, 64'd1);
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done, expected no pending run");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("err_count", 64'(err_count), 64'(e.err));
                    chk("sum_ed", 64'(sum_ed), 64'(e.sum));
                    chk("max_ed", 64'(max_ed), 64'(e.max));
                    chk("sum_sq_ed", 64'(sum_sq_ed), 64'(sq_exp(e.sq)));
                    chk("sat_sum_ed", 64'(sat_sum_ed), 64'(e.sat_sum));
                    chk("n_transfers", 64'(run_xfer), 64'(e.n_xfer));
                    chk("in_ready_low_at_done", {63'd0, in_ready}, 64'd0);
                    if (e.n_xfer > 0)
                        chk("done_latency_3to4", {63'd0, ((cyc - last_xfer) >= 3) && ((cyc - last_xfer) <= 4)}, 64'd1);
                    if (e.span >= 0)
                        chk("xfer_span", 64'(last_xfer - first_xfer), 64'(e.span));
                    if (e.start_lat >= 0)
                        chk("start_to_done", 64'(cyc - start_cyc), 64'(e.start_lat));
                end
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    //------------------------------------------------------------------
    // Driver helpers (drive 1 time unit after posedge)
    //------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] n);
        in_valid    = 1'b0;
        start       = 1'b1;
        num_samples = n;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] s, input logic c, input int gap);
        int t;
        in_valid = 1'b0;
        repeat (gap) tick();
        op_a = a; op_b = b; approx_sum = s; approx_cout = c;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected 1");
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_sb();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 1000) begin
            tick();
            t++;
        end
        if (t >= 1000) begin
            n_chk++;
            n_fail++;
            $display("FAIL run_timeout: got %0d runs pending, expected 0", sb.size());
            sb.delete();
        end
        tick();
    endtask

    function automatic exp_t mk(input logic [15:0] err, input logic [39:0] sum, input logic [16:0] mx,
                                input logic [49:0] sq, input logic [16:0] sat, input int n,
                                input int span, input int slat);
        exp_t e;
        e.err = err; e.sum = sum; e.max = mx; e.sq = sq; e.sat_sum = sat;
        e.n_xfer = n; e.span = span; e.start_lat = slat;
        return e;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    //------------------------------------------------------------------
    // Stimulus
    //------------------------------------------------------------------
    initial begin
        repeat (3) tick();
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        chk("rst_sum_ed", 64'(sum_ed), 64'd0);
        chk("rst_max_ed", 64'(max_ed), 64'd0);
        rst_n = 1'b1;
        tick();

        // Exact sample: 0x1234 + 0x0001 = 0x1235, ED = 0
        sb.push_back(mk(16'd0, 40'd0, 17'd0, 50'd0, 17'd0, 1, -1, -1));
        do_start(16'd1);
        send(16'h1234, 16'h0001, 16'h1235, 1'b0, 0);
        wait_sb();

        // Errored run, with a start pulse during RUN that must be ignored.
        // ED = 4 and ED = 0x10000: sum 0x10004, sq 16 + 2^32.
        sb.push_back(mk(16'd2, 40'h10004, 17'h10000, 50'h1_0000_0010, 17'h10004, 2, -1, -1));
        do_start(16'd2);
        send(16'd3, 16'd1, 16'd0, 1'b0, 0);
        do_start(16'd5);
        send(16'hFFFF, 16'd1, 16'd0, 1'b0, 0);
        wait_sb();

        // Zero-length run: done one cycle after start, no transfers.
        sb.push_back(mk(16'd0, 40'd0, 17'd0, 50'd0, 17'd0, 0, -1, 1));
        do_start(16'd0);
        in_valid = 1'b1;
        wait_sb();
        in_valid = 1'b0;

        // 100 samples, in_valid held high: sample i is i+i, every 10th approx is off by +1.
        sb.push_back(mk(16'd10, 40'd10, 17'd1, 50'd10, 17'd10, 100, 99, -1));
        do_start(16'd100);
        for (int i = 0; i < 100; i++)
            send(16'(i), 16'(i), 16'(2*i + ((i % 10 == 0) ? 1 : 0)), 1'b0, 0);
        wait_sb();

        // Same data with random gaps: identical stats.
        sb.push_back(mk(16'd10, 40'd10, 17'd1, 50'd10, 17'd10, 100, -1, -1));
        do_start(16'd100);
        for (int i = 0; i < 100; i++)
            send(16'(i), 16'(i), 16'(2*i + ((i % 10 == 0) ? 1 : 0)), 1'b0, int'($urandom_range(0, 2)));
        wait_sb();

        // Saturation: three ED = 0x10000 samples; 17-bit accumulator sticks at 0x1FFFF.
        sb.push_back(mk(16'd3, 40'h30000, 17'h10000, 50'h3_0000_0000, 17'h1FFFF, 3, -1, -1));
        do_start(16'd3);
        for (int i = 0; i < 3; i++)
            send(16'hFFFF, 16'd1, 16'd0, 1'b0, 0);
        wait_sb();

        // Reset mid-run: partial stats discarded immediately.
        do_start(16'd5);
        send(16'd3, 16'd1, 16'd0, 1'b0, 0);
        send(16'd3, 16'd1, 16'd0, 1'b0, 0);
        repeat (3) tick();
        chk("pre_rst_sum_ed", 64'(sum_ed), 64'd8);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("mid_rst_err_count", 64'(err_count), 64'd0);
        chk("mid_rst_sum_ed", 64'(sum_ed), 64'd0);
        chk("mid_rst_max_ed", 64'(max_ed), 64'd0);
        chk("mid_rst_sum_sq_ed", 64'(sum_sq_ed), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", {63'd0, busy}, 64'd0);
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd0);

        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL leftover_runs: got %0d pending, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
